// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encodings and small helpers for the decode-round sequencer.
// The PE array decodes global_stage with the same constants.
package decoder_stage_controller_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                = 3'd0,
        STAGE_MEASUREMENT_LOADING = 3'd1,
        STAGE_GROW                = 3'd2,
        STAGE_MERGE               = 3'd3,
        STAGE_PEELING             = 3'd4,
        STAGE_RESULT_VALID        = 3'd5,
        STAGE_WRITE_TO_MEM        = 3'd6,
        STAGE_RESET_ROOTS         = 3'd7
    } stage_e;

    // Bits needed to hold values 0..max_value. Never returns less than one bit.
    function automatic int count_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/decoder_stage_controller_settle.sv
// Settle detector for the array status lines. It counts cycles spent in the
// current stage and the run of quiet (busy_any==0) cycles seen after the
// status pipeline has caught up with the stage change.
module stage_settle_detector
    import decoder_stage_controller_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8,
    parameter int QUIET_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic                   busy_any,
    output logic                   stable,
    output logic [CNT_W-1:0]       stage_cycles
);

    logic [STAGE_WIDTH-1:0] last_stage;
    logic [CNT_W-1:0]       cycle_cnt;
    logic [QUIET_W-1:0]     quiet_cnt;
    logic                   stage_changed;
    logic [CNT_W-1:0]       cur_cycles;
    logic [QUIET_W-1:0]     cur_quiet;
    logic                   past_window;

    // A new stage value restarts both counts in its very first cycle, so the
    // counters read as zero there without needing an extra reset cycle.
    always_comb begin
        stage_changed = (stage != last_stage);
        cur_cycles    = stage_changed ? '0 : cycle_cnt;
        cur_quiet     = stage_changed ? '0 : quiet_cnt;
        past_window   = (cur_cycles >= CNT_W'(LATENCY));
        stable        = past_window && !busy_any && (cur_quiet == QUIET_W'(LATENCY));
        stage_cycles  = cur_cycles;
    end

    // Advance the stage-age counter and the quiet-run counter; busy during the
    // observation window throws away the run collected so far.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_stage <= STAGE_IDLE;
            cycle_cnt  <= '0;
            quiet_cnt  <= '0;
        end else begin
            last_stage <= stage;
            cycle_cnt  <= (cur_cycles == '1) ? cur_cycles : cur_cycles + 1'b1;
            if (!past_window || busy_any) begin
                quiet_cnt <= '0;
            end else if (cur_quiet != QUIET_W'(LATENCY + 1)) begin
                quiet_cnt <= cur_quiet + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_stage_controller.sv
// Global sequencer for one decode round: load, alternate merge/grow until no
// odd cluster remains (or a limit trips), peel, then hold the result until the
// reader takes it. Every output comes straight from registered state.
module decoder_stage_controller
    import decoder_stage_controller_pkg::*;
#(
    parameter int MAX_GROW_ITER    = 16,
    parameter int STATUS_LATENCY   = 2,
    parameter int MAX_MERGE_CYCLES = 255,
    parameter int CYCLE_CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 meas_valid,
    output logic                                 meas_ready,
    input  logic                                 busy_any,
    input  logic                                 odd_any,
    output logic [STAGE_WIDTH-1:0]               global_stage,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic [$clog2(MAX_GROW_ITER+1)-1:0]   grow_iterations,
    output logic [CYCLE_CNT_WIDTH-1:0]           decode_cycles,
    output logic                                 timeout
);

    localparam int GROW_W  = $clog2(MAX_GROW_ITER + 1);
    localparam int MERGE_W = count_width(MAX_MERGE_CYCLES);
    localparam int QUIET_W = count_width(STATUS_LATENCY + 1);

    stage_e                     stage;
    stage_e                     next_stage;
    logic [GROW_W-1:0]          grow_cnt;
    logic [CYCLE_CNT_WIDTH-1:0] cycle_cnt;
    logic                       timeout_flag;
    logic                       settled;
    logic [MERGE_W-1:0]         merge_cycles;
    logic                       watchdog_hit;
    logic                       grow_at_limit;
    logic                       start_round;
    logic                       enter_grow;
    logic                       set_timeout;

    stage_settle_detector #(
        .LATENCY (STATUS_LATENCY),
        .CNT_W   (MERGE_W),
        .QUIET_W (QUIET_W)
    ) u_settle (
        .clk          (clk),
        .reset        (reset),
        .stage        (stage),
        .busy_any     (busy_any),
        .stable       (settled),
        .stage_cycles (merge_cycles)
    );

    // Next-stage selection; a settled merge takes priority over the watchdog so
    // the watchdog only flags merges that genuinely never went quiet.
    always_comb begin
        next_stage    = stage;
        start_round   = 1'b0;
        enter_grow    = 1'b0;
        set_timeout   = 1'b0;
        watchdog_hit  = (merge_cycles == MERGE_W'(MAX_MERGE_CYCLES - 1));
        grow_at_limit = (grow_cnt >= GROW_W'(MAX_GROW_ITER));
        case (stage)
            STAGE_IDLE: begin
                if (meas_valid) begin
                    next_stage  = STAGE_MEASUREMENT_LOADING;
                    start_round = 1'b1;
                end
            end
            STAGE_MEASUREMENT_LOADING: next_stage = STAGE_MERGE;
            STAGE_GROW:                next_stage = STAGE_MERGE;
            STAGE_MERGE: begin
                if (settled) begin
                    if (odd_any && !grow_at_limit) begin
                        next_stage = STAGE_GROW;
                        enter_grow = 1'b1;
                    end else begin
                        next_stage  = STAGE_PEELING;
                        set_timeout = odd_any;
                    end
                end else if (watchdog_hit) begin
                    next_stage  = STAGE_PEELING;
                    set_timeout = 1'b1;
                end
            end
            STAGE_PEELING: next_stage = STAGE_RESULT_VALID;
            STAGE_RESULT_VALID: begin
                if (result_ready) begin
                    next_stage = STAGE_IDLE;
                end
            end
            default: next_stage = STAGE_IDLE;
        endcase
    end

    // Stage register broadcast to the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= STAGE_IDLE;
        end else begin
            stage <= next_stage;
        end
    end

    // Per-round statistics: cleared when a frame is accepted, then grow count,
    // sticky timeout and a saturating latency count that freezes at the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            grow_cnt     <= '0;
            cycle_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else if (start_round) begin
            grow_cnt     <= '0;
            cycle_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (enter_grow) begin
                grow_cnt <= grow_cnt + 1'b1;
            end
            if (set_timeout) begin
                timeout_flag <= 1'b1;
            end
            if (stage != STAGE_IDLE && stage != STAGE_RESULT_VALID && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

    assign global_stage    = stage;
    assign meas_ready      = (stage == STAGE_IDLE);
    assign result_valid    = (stage == STAGE_RESULT_VALID);
    assign grow_iterations = grow_cnt;
    assign decode_cycles   = cycle_cnt;
    assign timeout         = timeout_flag;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Bench for decoder_stage_controller: a round-level reference model checked
// every cycle, directed rounds with hand-computed results, then random traffic.
module tb_decoder_stage_controller;

    localparam int LAT = 2;
    localparam int MG  = 3;
    localparam int MM  = 20;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          meas_valid;
    logic          meas_ready;
    logic          busy_any;
    logic          odd_any;
    logic [2:0]    global_stage;
    logic          result_valid;
    logic          result_ready;
    logic [1:0]    grow_iterations;
    logic [CW-1:0] decode_cycles;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    int m_stage, m_grow, m_cyc, m_to;
    bit m_ok = 0;
    int hist[$];
    int prev_stage = 0;
    int seq_code = 0;
    int grow_seen = 0;

    decoder_stage_controller #(
        .MAX_GROW_ITER    (MG),
        .STATUS_LATENCY   (LAT),
        .MAX_MERGE_CYCLES (MM),
        .CYCLE_CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .meas_valid      (meas_valid),
        .meas_ready      (meas_ready),
        .busy_any        (busy_any),
        .odd_any         (odd_any),
        .global_stage    (global_stage),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .grow_iterations (grow_iterations),
        .decode_cycles   (decode_cycles),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic rr, input logic b, input logic o);
        meas_valid   = mv;
        result_ready = rr;
        busy_any     = b;
        odd_any      = o;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitStage(input int s, input int max_cycles);
        int n = 0;
        while (global_stage !== 3'(s) && n < max_cycles) begin
            stepCycles(1);
            n++;
        end
        if (global_stage !== 3'(s)) checkOutput("wait_stage", 32'(global_stage), 32'(s));
    endtask

    task automatic startRound(input logic b, input logic o);
        applyStimulus(1'b1, 1'b0, b, o);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, b, o);
    endtask

    task automatic releaseResult();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkRound(input string tag, input int cyc, input int grow, input int to);
        checkOutput({tag, "_decode_cycles"}, 32'(decode_cycles), 32'(cyc));
        checkOutput({tag, "_grow_iterations"}, 32'(grow_iterations), 32'(grow));
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'(to));
    endtask

    // Reference model and per-cycle compare. At each falling edge the model
    // holds the state the DUT should show, then advances using the inputs the
    // DUT will sample on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                checkOutput("stage", 32'(global_stage), 32'(m_stage));
                checkOutput("meas_ready", 32'(meas_ready), 32'(m_stage == 0));
                checkOutput("result_valid", 32'(result_valid), 32'(m_stage == 5));
                checkOutput("grow_iterations", 32'(grow_iterations), 32'(m_grow));
                checkOutput("decode_cycles", 32'(decode_cycles), 32'(m_cyc));
                checkOutput("timeout", 32'(timeout), 32'(m_to));
            end
            if (int'(global_stage) != prev_stage) begin
                if (global_stage == 3'd1) begin
                    seq_code  = 1;
                    grow_seen = 0;
                end else if (global_stage != 3'd0) begin
                    seq_code = seq_code * 8 + int'(global_stage);
                    if (global_stage == 3'd2) grow_seen++;
                end
                prev_stage = int'(global_stage);
            end
            if (reset === 1'b1) begin
                m_stage = 0; m_grow = 0; m_cyc = 0; m_to = 0;
                hist.delete();
                m_ok = 1;
            end else if (m_ok) begin
                if (m_stage >= 1 && m_stage <= 4 && m_cyc < CMAX) m_cyc++;
                case (m_stage)
                    0: if (meas_valid) begin
                        m_stage = 1; m_grow = 0; m_cyc = 0; m_to = 0;
                    end
                    1, 2: begin
                        m_stage = 3;
                        hist.delete();
                    end
                    3: begin
                        int k;
                        bit quiet;
                        hist.push_back(int'(busy_any));
                        k = hist.size() - 1;
                        quiet = (k >= 2 * LAT);
                        if (quiet) for (int j = k - LAT; j <= k; j++) if (hist[j] != 0) quiet = 0;
                        if (quiet) begin
                            if (odd_any && m_grow < MG) begin
                                m_grow++;
                                m_stage = 2;
                            end else begin
                                if (odd_any) m_to = 1;
                                m_stage = 4;
                            end
                        end else if (k + 1 >= MM) begin
                            m_to = 1;
                            m_stage = 4;
                        end
                    end
                    4: m_stage = 5;
                    5: if (result_ready) m_stage = 0;
                    default: m_stage = 0;
                endcase
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL global_time_limit: got stuck, expected to finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int busy_pct;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("reset_stage", 32'(global_stage), 32'd0);
        checkOutput("reset_meas_ready", 32'(meas_ready), 32'd1);
        checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
        checkOutput("reset_counters", 32'({grow_iterations, decode_cycles, timeout}), 32'd0);
        reset = 1'b0;
        stepCycles(1);

        // Zero defects: stages 1,3,4,5 and 1 + 5 + 1 cycles.
        startRound(1'b0, 1'b0);
        waitStage(5, 100);
        checkRound("zero_defect", 7, 0, 0);
        releaseResult();
        checkOutput("zero_defect_sequence", 32'(seq_code), 32'o1345);
        checkOutput("zero_defect_grow_stages", 32'(grow_seen), 32'd0);

        // Odd on the first merge only: exactly one grow.
        startRound(1'b0, 1'b1);
        waitStage(2, 50);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitStage(5, 100);
        checkRound("one_grow", 13, 1, 0);
        releaseResult();
        checkOutput("one_grow_sequence", 32'(seq_code), 32'o132345);

        // Odd tied high: three grows then forced peel; latency saturates.
        startRound(1'b0, 1'b1);
        waitStage(5, 200);
        checkRound("grow_limit", CMAX, 3, 1);
        releaseResult();
        checkOutput("grow_limit_sequence", 32'(seq_code), 32'o1323232345);
        checkOutput("grow_limit_grow_stages", 32'(grow_seen), 32'd3);

        // Busy tied high: watchdog ends the merge after 20 cycles.
        startRound(1'b1, 1'b0);
        waitStage(3, 10);
        stepCycles(MM - 1);
        checkOutput("watchdog_still_merge", 32'(global_stage), 32'd3);
        stepCycles(1);
        checkOutput("watchdog_peel", 32'(global_stage), 32'd4);
        waitStage(5, 10);
        checkRound("watchdog", CMAX, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Result held while the reader stalls; simultaneous accept is refused.
        for (int i = 0; i < 10; i++) begin
            stepCycles(1);
            checkOutput("hold_result_valid", 32'(result_valid), 32'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("handshake_idle", 32'(global_stage), 32'd0);
        checkOutput("handshake_meas_ready", 32'(meas_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("handshake_accept", 32'(global_stage), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitStage(5, 100);
        releaseResult();

        // Reset in the middle of a merge.
        startRound(1'b1, 1'b1);
        waitStage(3, 10);
        stepCycles(3);
        reset = 1'b1;
        stepCycles(1);
        reset = 1'b0;
        checkOutput("midreset_stage", 32'(global_stage), 32'd0);
        checkOutput("midreset_meas_ready", 32'(meas_ready), 32'd1);
        checkOutput("midreset_counters", 32'({grow_iterations, decode_cycles, timeout}), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycles(2);

        // Busy glitch in the quiet window stretches the merge to 7 cycles.
        startRound(1'b0, 1'b0);
        waitStage(3, 10);
        stepCycles(3);
        busy_any = 1'b1;
        stepCycles(1);
        busy_any = 1'b0;
        waitStage(5, 100);
        checkRound("glitch", 9, 0, 0);
        releaseResult();

        // Random traffic against the model.
        busy_pct = 25;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: busy_pct = 10;
                    1: busy_pct = 40;
                    default: busy_pct = 90;
                endcase
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 99) < busy_pct, $urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 599) == 0);
            stepCycles(1);
        end
        reset = 1'b0;
        stepCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
